pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/cpu_pkg.sv | 18 +
 rtl/next_pc_select.sv | 42 ++++
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths and PC sequencer state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_PC_WIDTH    = 32;
    localparam int c_INSTR_WIDTH = 16;

    // Sequencer states
    localparam logic [1:0] c_BOOT_LO = 2'd0;
    localparam logic [1:0] c_BOOT_HI = 2'd1;
    localparam logic [1:0] c_RUN     = 2'd2;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/next_pc_select.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_select
// Description : Next-PC priority mux: taken branch > direct jump > hold >
//               sequential increment. Flags any accepted redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_select
    import cpu_pkg::*;
#(
    parameter logic [c_PC_WIDTH-1:0] PC_INC = 32'd1
) (
    input  logic [c_PC_WIDTH-1:0]    i_pc,
    input  logic                     i_stall,
    input  logic                     i_hold,
    input  logic                     i_jump_occured,
    input  logic [c_INSTR_WIDTH-1:0] i_jump_to,
    input  logic                     i_direct_jump,
    input  logic [c_INSTR_WIDTH-1:0] i_direct_jump_to,
    output logic [c_PC_WIDTH-1:0]    o_next_pc,
    output logic                     o_redirect
);

    localparam int c_EXT_WIDTH = c_PC_WIDTH - c_INSTR_WIDTH;

    // Redirects win over any hold; the increment wraps naturally at 32 bits
    always_comb begin
        o_next_pc  = i_pc + PC_INC;
        o_redirect = 1'b0;
        if (i_jump_occured) begin
            o_next_pc  = {{c_EXT_WIDTH{1'b0}}, i_jump_to};
            o_redirect = 1'b1;
        end else if (i_direct_jump) begin
            o_next_pc  = {{c_EXT_WIDTH{1'b0}}, i_direct_jump_to};
            o_redirect = 1'b1;
        end else if (i_stall || i_hold) begin
            o_next_pc  = i_pc;
        end
    end

endmodule : next_pc_select
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch PC sequencer. Loads the 32-bit boot PC from two
//               16-bit memory words, then steps/redirects the PC. A program
//               loader may take the memory port at any time.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [c_PC_WIDTH-1:0] RESET_VECTOR_ADDR = 32'h0000_0000,
    parameter logic [c_PC_WIDTH-1:0] PC_INC            = 32'd1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_we,
    input  logic [c_PC_WIDTH-1:0]    load_addr,
    input  logic [c_INSTR_WIDTH-1:0] load_data,
    input  logic                     stall,
    input  logic                     jump_occured,
    input  logic [c_INSTR_WIDTH-1:0] jump_to,
    input  logic                     direct_jump,
    input  logic [c_INSTR_WIDTH-1:0] direct_jump_to,
    input  logic [c_INSTR_WIDTH-1:0] mem_rdata,
    output logic [c_PC_WIDTH-1:0]    mem_addr,
    output logic                     mem_we,
    output logic [c_INSTR_WIDTH-1:0] mem_wdata,
    output logic [c_PC_WIDTH-1:0]    pc,
    output logic                     fetch_valid,
    output logic                     flush,
    output logic                     booting
);

    localparam logic [c_PC_WIDTH-1:0] c_BOOT_HI_ADDR = RESET_VECTOR_ADDR + 32'd1;

    logic [1:0]            r_state;
    logic [c_PC_WIDTH-1:0] r_pc;
    logic [c_PC_WIDTH-1:0] w_next_pc;
    logic                  w_redirect;

    next_pc_select #(
        .PC_INC (PC_INC)
    ) u_next_pc_select (
        .i_pc             (r_pc),
        .i_stall          (stall),
        .i_hold           (load_we),
        .i_jump_occured   (jump_occured),
        .i_jump_to        (jump_to),
        .i_direct_jump    (direct_jump),
        .i_direct_jump_to (direct_jump_to),
        .o_next_pc        (w_next_pc),
        .o_redirect       (w_redirect)
    );

    // Boot fetches the PC halves in two steps; the loader freezes boot progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_BOOT_LO;
            r_pc    <= '0;
        end else begin
            case (r_state)
                c_BOOT_LO: begin
                    if (!load_we) begin
                        r_pc[c_INSTR_WIDTH-1:0] <= mem_rdata;
                        r_state                 <= c_BOOT_HI;
                    end
                end
                c_BOOT_HI: begin
                    if (!load_we) begin
                        r_pc[c_PC_WIDTH-1:c_INSTR_WIDTH] <= mem_rdata;
                        r_state                          <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_pc <= w_next_pc;
                end
                default: begin
                    r_state <= c_BOOT_LO;
                end
            endcase
        end
    end

    // Memory port: loader has priority, otherwise boot vector or fetch PC
    always_comb begin
        mem_addr = r_pc;
        if (load_we) begin
            mem_addr = load_addr;
        end else if (r_state == c_BOOT_LO) begin
            mem_addr = RESET_VECTOR_ADDR;
        end else if (r_state == c_BOOT_HI) begin
            mem_addr = c_BOOT_HI_ADDR;
        end
    end

    assign mem_we      = load_we;
    assign mem_wdata   = load_we ? load_data : '0;
    assign pc          = r_pc;
    assign booting     = (r_state != c_RUN);
    assign fetch_valid = (r_state == c_RUN) && !load_we;
    assign flush       = (r_state == c_RUN) && w_redirect;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer with a small
//               instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        load_we;
    logic [31:0] load_addr;
    logic [15:0] load_data;
    logic        stall;
    logic        jump_occured;
    logic [15:0] jump_to;
    logic        direct_jump;
    logic [15:0] direct_jump_to;
    logic [15:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush;
    logic        booting;

    logic [15:0] mem [0:255];
    logic        tb_we;
    logic [7:0]  tb_addr;
    logic [15:0] tb_data;

    int n_checks;
    int n_errors;

    pc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .stall          (stall),
        .jump_occured   (jump_occured),
        .jump_to        (jump_to),
        .direct_jump    (direct_jump),
        .direct_jump_to (direct_jump_to),
        .mem_rdata      (mem_rdata),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .pc             (pc),
        .fetch_valid    (fetch_valid),
        .flush          (flush),
        .booting        (booting)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, clocked write (DUT port or bench preload)
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        else if (tb_we) mem[tb_addr] <= tb_data;
    end

    typedef struct {
        logic        stall;
        logic        jo;
        logic [15:0] jt;
        logic        dj;
        logic [15:0] djt;
        logic        lw;
        logic [31:0] la;
        logic [15:0] ld;
        logic        e_flush;
        logic        e_fv;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vec [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic clear_inputs();
        load_we = 0; load_addr = 0; load_data = 0; stall = 0;
        jump_occured = 0; jump_to = 0; direct_jump = 0; direct_jump_to = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        tb_we = 0; tb_addr = 0; tb_data = 0;
        clear_inputs();
        rst = 1'b1;

        //            stall jo  jt        dj  djt       lw  la     ld        fl  fv  addr          pc
        vec[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'd0, 16'h0000, 1'b0, 1'b1, 32'h10,    32'h11};
        vec[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'd0, 16'h0000, 1'b0, 1'b1, 32'h11,    32'h11};
        vec[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b0, 32'd0, 16'h0000, 1'b1, 1'b1, 32'h11,    32'h20};
        vec[3]  = '{1'b1, 1'b1, 16'h0040, 1'b1, 16'h0080, 1'b0, 32'd0, 16'h0000, 1'b1, 1'b1, 32'h20,    32'h40};
        vec[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'd0, 16'h0000, 1'b0, 1'b1, 32'h40,    32'h41};
        vec[5]  = '{1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 32'd0, 16'h0000, 1'b1, 1'b1, 32'h41,    32'h100};
        vec[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 32'd7, 16'h1234, 1'b0, 1'b0, 32'h7,     32'h100};
        vec[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0030, 1'b1, 32'd7, 16'h5678, 1'b1, 1'b0, 32'h7,     32'h30};
        vec[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 32'd0, 16'h0000, 1'b1, 1'b1, 32'h30,    32'hFFFF};
        vec[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'd0, 16'h0000, 1'b0, 1'b1, 32'hFFFF,  32'h10000};
        vec[10] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'd0, 16'h0000, 1'b1, 1'b1, 32'h10000, 32'h0};
        vec[11] = '{1'b0, 1'b1, 16'h0030, 1'b1, 16'h0099, 1'b0, 32'd0, 16'h0000, 1'b1, 1'b1, 32'h0,     32'h30};

        // ---------------- Reset state and boot ----------------
        preload(8'd0, 16'h0010);
        preload(8'd1, 16'h0000);
        check("rst_pc", pc, 32'h0);
        check("rst_booting", {31'd0, booting}, 32'd1);
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("boot_lo_addr", mem_addr, 32'h0);
        check("boot_lo_booting", {31'd0, booting}, 32'd1);
        tick();
        check("boot_hi_addr", mem_addr, 32'h1);
        check("boot_hi_booting", {31'd0, booting}, 32'd1);
        check("boot_hi_pc", pc, 32'h10);
        tick();
        check("run_pc", pc, 32'h10);
        check("run_booting", {31'd0, booting}, 32'd0);
        check("run_fetch_valid", {31'd0, fetch_valid}, 32'd1);

        // ---------------- Table-driven run-state vectors ----------------
        for (int i = 0; i < 12; i++) begin
            stall = vec[i].stall;
            jump_occured = vec[i].jo;
            jump_to = vec[i].jt;
            direct_jump = vec[i].dj;
            direct_jump_to = vec[i].djt;
            load_we = vec[i].lw;
            load_addr = vec[i].la;
            load_data = vec[i].ld;
            #1;
            check($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vec[i].e_flush});
            check($sformatf("v%0d_fetch_valid", i), {31'd0, fetch_valid}, {31'd0, vec[i].e_fv});
            check($sformatf("v%0d_mem_addr", i), mem_addr, vec[i].e_addr);
            check($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vec[i].lw});
            check($sformatf("v%0d_mem_wdata", i), {16'd0, mem_wdata},
                  {16'd0, (vec[i].lw ? vec[i].ld : 16'h0000)});
            tick();
            check($sformatf("v%0d_pc", i), pc, vec[i].e_pc);
        end
        clear_inputs();
        #1;
        check("after_table_flush", {31'd0, flush}, 32'd0);

        // ---------------- Loader for 3 cycles at pc=0x30 ----------------
        load_we = 1'b1; load_addr = 32'd5; load_data = 16'hBEEF;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("ld%0d_mem_we", c), {31'd0, mem_we}, 32'd1);
            check($sformatf("ld%0d_mem_addr", c), mem_addr, 32'd5);
            check($sformatf("ld%0d_fetch_valid", c), {31'd0, fetch_valid}, 32'd0);
            tick();
            check($sformatf("ld%0d_pc", c), pc, 32'h30);
        end
        clear_inputs();
        #1;
        check("ld_resume_addr", mem_addr, 32'h30);
        check("ld_resume_we", {31'd0, mem_we}, 32'd0);
        tick();
        check("ld_resume_pc", pc, 32'h31);
        check("ld_mem5", {16'd0, mem[5]}, 32'h0000BEEF);

        // ---------------- Asynchronous reset mid-run ----------------
        direct_jump = 1'b1; direct_jump_to = 16'h0055;
        tick();
        clear_inputs();
        check("pre_rst_pc", pc, 32'h55);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_booting", {31'd0, booting}, 32'd1);
        check("async_rst_addr", mem_addr, 32'h0);
        check("async_rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);

        // Reboot with vector 0xFFFF_FFFF, loader active during BOOT_HI
        preload(8'd0, 16'hFFFF);
        preload(8'd1, 16'hFFFF);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("reboot_lo_pc", pc, 32'h0000FFFF);
        load_we = 1'b1; load_addr = 32'd9; load_data = 16'hAAAA;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("bhld%0d_addr", c), mem_addr, 32'd9);
            check($sformatf("bhld%0d_fetch_valid", c), {31'd0, fetch_valid}, 32'd0);
            tick();
            check($sformatf("bhld%0d_booting", c), {31'd0, booting}, 32'd1);
            check($sformatf("bhld%0d_pc", c), pc, 32'h0000FFFF);
        end
        clear_inputs();
        #1;
        check("bh_resume_addr", mem_addr, 32'h1);
        tick();
        check("bh_done_pc", pc, 32'hFFFFFFFF);
        check("bh_done_booting", {31'd0, booting}, 32'd0);
        check("wrap_flush", {31'd0, flush}, 32'd0);
        tick();
        check("wrap_pc", pc, 32'h0);
        check("wrap_fetch_valid", {31'd0, fetch_valid}, 32'd1);
        check("bh_mem9", {16'd0, mem[9]}, 32'h0000AAAA);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
